serializer_tx: RTL and testbench
================================

// Module: serializer_tx
// PURPOSE
//  Parallel-to-serial transmit stage feeding the lane deserializer.
//  - Accepts DATA_WIDTH-bit words over a valid/ready handshake.
//  - Frames each word as: start bit (0), data MSB-first, then STOP_BITS ones.
//  - Drives one serial bit per clk. Line idles high.
//  - A one-entry holding buffer allows back-to-back frames with no idle gap.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame; must be >= 2
//  STOP_BITS   1  number of high stop bits per frame; must be >= 1 (0 = elaboration error)
// PORTS
//  clk          in   1           single clock; all logic on posedge
//  rst          in   1           asynchronous, active-low reset
//  data_in      in   DATA_WIDTH  parallel word to send
//  data_valid   in   1           data_in valid
//  data_ready   out  1           block can take data_in this cycle
//  serial_out   out  1           serial line, registered, idle = 1
//  busy         out  1           1 while a frame (start/data/stop) is on the line
//  frame_done   out  1           1-cycle pulse on the last stop-bit cycle
// BEHAVIOUR
//  Reset (rst=0, async):
//   - serial_out=1, busy=0, frame_done=0, FSM=IDLE, hold buffer empty -> data_ready=1.
//   - Reset mid-frame aborts the frame. Line returns high immediately.
//   - Any held word is discarded.
//  Handshake:
//   - A word is accepted on a posedge with data_valid && data_ready.
//   - data_ready = !hold_valid || hold_load. This is combinational, so a new word
//     can be accepted on the same edge the held word moves into the shifter.
//   - data_in is ignored while not accepted. No output depends combinationally on data_valid.
//  FSM states IDLE, START, DATA, STOP:
//   - IDLE -> START when hold_valid. Shifter <= hold word. serial_out <= 0.
//   - START -> DATA (1 cycle). serial_out <= shifter MSB. bit_cnt <= 0.
//   - DATA: shift left each cycle, bit_cnt++. After DATA_WIDTH bits -> STOP. serial_out <= 1.
//   - STOP: lasts STOP_BITS cycles; stop_cnt counts up.
//     - On the last stop cycle, frame_done=1.
//     - If hold_valid, go to START (back-to-back). Otherwise go to IDLE.
//  Timing (accept at edge N, buffer previously empty, FSM in IDLE):
//   - Start bit is driven from edge N+1.
//   - Data bit k (MSB=0) is driven from edge N+2+k.
//   - Stop bits are driven from edge N+2+DATA_WIDTH.
//   - Frame period = 1 + DATA_WIDTH + STOP_BITS cycles.
//   - Back-to-back streaming has zero idle cycles.
//  busy: 1 in START/DATA/STOP, registered with the FSM.
//  Counters:
//   - bit_cnt is $clog2(DATA_WIDTH) wide. stop_cnt is $clog2(STOP_BITS+1) wide.
//   - Both clear on frame entry. Neither ever wraps inside a frame.
//  Full buffer while shifting: data_ready=0 until the hold word is loaded.
//   The upstream block must stall.
// STRUCTURE
//  serializer_pkg:
//   - typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
//   - localparam LINE_IDLE = 1'b1; localparam START_BIT = 1'b0.
//  Sub-module serializer_hold_buf:
//   - 1-entry buffer with ports push/pop/din/dout/valid.
//   - Supports push and pop on the same edge.
//  Top contains the FSM, shifter, counters and output registers.
// TESTING
//  1. Send 8'hA5 once, STOP_BITS=1 -> serial_out 0,1,0,1,0,0,1,0,1,1 from edge N+1;
//     frame_done pulses once at edge N+10; busy drops the next cycle.
//  2. Hold data_valid high with 8'h3C, 8'hFF, 8'h00 -> three contiguous 10-bit frames,
//     no idle bit between them; data_ready deasserts while the buffer is full.
//  3. STOP_BITS=2, send 8'h81 -> 0,1,0,0,0,0,0,0,1,1,1; frame period 11 cycles.
//  4. Assert rst low during data bit 4 of 8'hF0 -> serial_out=1 and busy=0 immediately;
//     after release, idle until a new word arrives; the old held word is never sent.
//  5. Toggle data_in while data_ready=0 -> the transmitted word equals the value
//     present at the accepting edge.
//  6. Loopback into the lane deserializer with random words (1000 frames) ->
//     every received word matches in order.

Source files
------------

// File: rtl/serializer_pkg.sv
// ---------------------------------------------------------------------------
// serializer_pkg
// Shared types and line-level constants for the serializer transmit stage.
//   tx_state_e : transmit FSM states (IDLE, START, DATA, STOP)
//   LINE_IDLE  : level of an idle line and of every stop bit
//   START_BIT  : level of the start bit that opens each frame
// ---------------------------------------------------------------------------
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serializer_tx_if.sv
// ---------------------------------------------------------------------------
// serializer_tx_if
// Bundles the parallel handshake and the serial-side outputs of serializer_tx.
//   data_in    : parallel word offered by the upstream block
//   data_valid : data_in is valid
//   data_ready : transmitter can take data_in this cycle
//   serial_out : registered serial line, idles high
//   busy       : a frame is on the line
//   frame_done : one-cycle pulse during the last stop bit
// Modports:
//   master : upstream side (drives the word, observes the rest)
//   slave  : the transmitter itself
// ---------------------------------------------------------------------------
interface serializer_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic                  serial_out;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  serial_out,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output serial_out,
    output busy,
    output frame_done
  );

endinterface

// File: rtl/serializer_hold_buf.sv
// ---------------------------------------------------------------------------
// serializer_hold_buf
// One-entry holding register between the handshake and the shifter.
//   clk   : clock, posedge
//   rst   : asynchronous reset, active low; empties the buffer
//   push  : store din (caller guarantees space, or pops on the same edge)
//   pop   : the stored word is consumed this edge
//   din   : word to store
//   dout  : stored word
//   valid : buffer holds a word
// ---------------------------------------------------------------------------
module serializer_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Push wins over pop so a word can be refilled on the same edge the old
  // one leaves for the shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (push) begin
        r_data <= din;
      end
      if (push) begin
        r_valid <= 1'b1;
      end else if (pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dout  = r_data;
  assign valid = r_valid;

endmodule

// File: rtl/serializer_tx.sv
// ---------------------------------------------------------------------------
// serializer_tx
// Parallel-to-serial transmitter. Each accepted word goes out as one start
// bit (0), DATA_WIDTH data bits MSB first, then STOP_BITS ones. The line
// idles high. A one-entry hold buffer lets frames stream with no idle gap.
//   clk : clock, posedge
//   rst : asynchronous reset, active low; aborts any frame, drops held word
//   bus : serializer_tx_if slave (data_in/data_valid/data_ready,
//         serial_out/busy/frame_done)
// Parameters:
//   DATA_WIDTH : payload bits per frame (>= 2)
//   STOP_BITS  : stop bits per frame (>= 1)
// ---------------------------------------------------------------------------
module serializer_tx
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  serializer_tx_if.slave  bus
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int SW = $clog2(STOP_BITS + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

  if (STOP_BITS < 1 || DATA_WIDTH < 2) begin : g_paramCheck
    $error("serializer_tx: DATA_WIDTH must be >= 2 and STOP_BITS >= 1");
  end

  tx_state_e             r_state;
  tx_state_e             w_nextState;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_nextShift;
  logic [BW-1:0]         r_bitCnt;
  logic [BW-1:0]         w_nextBitCnt;
  logic [SW-1:0]         r_stopCnt;
  logic [SW-1:0]         w_nextStopCnt;
  logic                  r_serialOut;
  logic                  w_nextSerial;
  logic                  r_busy;
  logic                  r_frameDone;
  logic                  w_nextFrameDone;

  logic                  w_holdValid;
  logic                  w_holdLoad;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_holdData;

  // Ready only looks at registered state plus the load decision, so nothing
  // depends combinationally on data_valid.
  assign bus.data_ready = !w_holdValid || w_holdLoad;
  assign w_push         = bus.data_valid && bus.data_ready;

  serializer_hold_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_holdBuf (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_holdLoad),
    .din   (bus.data_in),
    .dout  (w_holdData),
    .valid (w_holdValid)
  );

  // Next-state logic. serial_out is registered, so every branch decides the
  // level the line will carry from the coming edge. bit_cnt and stop_cnt
  // track the index of the bit currently on the line.
  always_comb begin
    w_nextState     = r_state;
    w_nextShift     = r_shift;
    w_nextBitCnt    = r_bitCnt;
    w_nextStopCnt   = r_stopCnt;
    w_nextSerial    = r_serialOut;
    w_nextFrameDone = 1'b0;
    w_holdLoad      = 1'b0;

    case (r_state)
      IDLE: begin
        w_nextSerial = LINE_IDLE;
        if (w_holdValid) begin
          w_holdLoad    = 1'b1;
          w_nextState   = START;
          w_nextShift   = w_holdData;
          w_nextBitCnt  = '0;
          w_nextStopCnt = '0;
          w_nextSerial  = START_BIT;
        end
      end

      START: begin
        w_nextState  = DATA;
        w_nextSerial = r_shift[DATA_WIDTH-1];
        w_nextShift  = {r_shift[DATA_WIDTH-2:0], 1'b0};
        w_nextBitCnt = '0;
      end

      DATA: begin
        if (r_bitCnt == BIT_LAST) begin
          w_nextState     = STOP;
          w_nextSerial    = LINE_IDLE;
          w_nextStopCnt   = '0;
          w_nextFrameDone = (STOP_BITS == 1);
        end else begin
          w_nextSerial = r_shift[DATA_WIDTH-1];
          w_nextShift  = {r_shift[DATA_WIDTH-2:0], 1'b0};
          w_nextBitCnt = r_bitCnt + BW'(1);
        end
      end

      STOP: begin
        if (r_stopCnt == STOP_LAST) begin
          // Frame ends here; chain straight into the next one if a word waits.
          if (w_holdValid) begin
            w_holdLoad    = 1'b1;
            w_nextState   = START;
            w_nextShift   = w_holdData;
            w_nextBitCnt  = '0;
            w_nextStopCnt = '0;
            w_nextSerial  = START_BIT;
          end else begin
            w_nextState  = IDLE;
            w_nextSerial = LINE_IDLE;
          end
        end else begin
          w_nextSerial    = LINE_IDLE;
          w_nextStopCnt   = r_stopCnt + SW'(1);
          w_nextFrameDone = ((r_stopCnt + SW'(1)) == STOP_LAST);
        end
      end

      default: begin
        w_nextState  = IDLE;
        w_nextSerial = LINE_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_stopCnt   <= '0;
      r_serialOut <= LINE_IDLE;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_shift     <= w_nextShift;
      r_bitCnt    <= w_nextBitCnt;
      r_stopCnt   <= w_nextStopCnt;
      r_serialOut <= w_nextSerial;
      r_busy      <= (w_nextState != IDLE);
      r_frameDone <= w_nextFrameDone;
    end
  end

  assign bus.serial_out = r_serialOut;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frameDone;

endmodule

// File: tb/tb_serializer_tx.sv
// ---------------------------------------------------------------------------
// tb_serializer_tx
// Directed bench for serializer_tx. Two instances share clock and reset:
// dut1 with one stop bit, dut2 with two stop bits.
// ---------------------------------------------------------------------------
module tb_serializer_tx;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  serializer_tx_if #(.DATA_WIDTH(8)) bus1 ();
  serializer_tx_if #(.DATA_WIDTH(8)) bus2 ();

  serializer_tx #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  serializer_tx #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    bit         sel;
    logic [7:0] data;
    int         nbits;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[6];

  // Records one comparison; X/Z on the actual value counts as a miss
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives the handshake of the selected instance
  task automatic applyStimulus(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      bus2.data_valid = v;
      bus2.data_in    = d;
    end else begin
      bus1.data_valid = v;
      bus1.data_in    = d;
    end
  endtask

  function automatic logic getSerial(input bit sel);
    return sel ? bus2.serial_out : bus1.serial_out;
  endfunction

  function automatic logic getBusy(input bit sel);
    return sel ? bus2.busy : bus1.busy;
  endfunction

  function automatic logic getDone(input bit sel);
    return sel ? bus2.frame_done : bus1.frame_done;
  endfunction

  function automatic logic getReady(input bit sel);
    return sel ? bus2.data_ready : bus1.data_ready;
  endfunction

  // Reference framing: bit 0 start, bits 1..8 data MSB first, then stop ones
  function automatic logic frameBit(input logic [7:0] w, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return w[8-j];
    return 1'b1;
  endfunction

  // Single frame from an idle instance, checked against a hand-written frame
  task automatic sendFrame(input bit sel, input logic [7:0] data, input int nbits,
                           input logic [10:0] frame, input string tag);
    checkOutput({tag, " ready idle"}, 32'(getReady(sel)), 32'd1);
    applyStimulus(sel, 1'b1, data);
    @(posedge clk); #1;
    applyStimulus(sel, 1'b0, 8'h00);
    checkOutput({tag, " line before start"}, 32'(getSerial(sel)), 32'd1);
    checkOutput({tag, " busy before start"}, 32'(getBusy(sel)), 32'd0);
    for (int k = 0; k < nbits; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s bit%0d", tag, k), 32'(getSerial(sel)), 32'(frame[nbits-1-k]));
      checkOutput($sformatf("%s done%0d", tag, k), 32'(getDone(sel)), 32'(k == nbits - 1));
      checkOutput($sformatf("%s busy%0d", tag, k), 32'(getBusy(sel)), 32'd1);
    end
    @(posedge clk); #1;
    checkOutput({tag, " busy after"}, 32'(getBusy(sel)), 32'd0);
    checkOutput({tag, " line after"}, 32'(getSerial(sel)), 32'd1);
    checkOutput({tag, " done after"}, 32'(getDone(sel)), 32'd0);
  endtask

  // Streams up to three words with data_valid held high and checks the line
  // is one unbroken run of frames. With scramble set, data_in is randomised
  // every stalled cycle and only the intended word is present at acceptance.
  task automatic runStream(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input int n, input bit scramble,
                           input int expStall, input string tag);
    logic [7:0] words[3];
    int fb;
    int stall;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    fb    = sel ? 11 : 10;
    stall = 0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int guard;
          applyStimulus(sel, 1'b1, words[i]);
          for (guard = 0; guard < 40; guard++) begin
            @(negedge clk);
            if (getReady(sel)) begin
              applyStimulus(sel, 1'b1, words[i]);
              break;
            end
            stall++;
            if (scramble) applyStimulus(sel, 1'b1, 8'($urandom_range(0, 255)));
          end
          if (guard == 40) checkOutput({tag, " accept timeout"}, 32'd0, 32'd1);
          @(posedge clk); #1;
        end
        applyStimulus(sel, 1'b0, 8'h00);
      end
      begin
        int t;
        for (t = 0; t < 60; t++) begin
          @(posedge clk); #1;
          if (getSerial(sel) === 1'b0) break;
        end
        if (t == 60) begin
          checkOutput({tag, " start timeout"}, 32'd0, 32'd1);
        end else begin
          for (int j = 0; j < n * fb; j++) begin
            if (j > 0) begin
              @(posedge clk); #1;
            end
            checkOutput($sformatf("%s bit%0d", tag, j), 32'(getSerial(sel)),
                        32'(frameBit(words[j / fb], j % fb)));
            checkOutput($sformatf("%s done%0d", tag, j), 32'(getDone(sel)),
                        32'((j % fb) == fb - 1));
          end
          @(posedge clk); #1;
          checkOutput({tag, " line after"}, 32'(getSerial(sel)), 32'd1);
          checkOutput({tag, " busy after"}, 32'(getBusy(sel)), 32'd0);
        end
      end
    join
    checkOutput({tag, " stall cycles"}, 32'(stall), 32'(expStall));
  endtask

  initial begin
    // Hand-computed frames: start, data MSB first, stop bit(s)
    vecs[0] = '{1'b0, 8'hA5, 10, 11'b00101001011};
    vecs[1] = '{1'b0, 8'h5A, 10, 11'b00010110101};
    vecs[2] = '{1'b0, 8'hFF, 10, 11'b00111111111};
    vecs[3] = '{1'b0, 8'h00, 10, 11'b00000000001};
    vecs[4] = '{1'b1, 8'h81, 11, 11'b01000000111};
    vecs[5] = '{1'b1, 8'h3C, 11, 11'b00011110011};

    // Reset state on both instances
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("reset line dut%0d", s + 1), 32'(getSerial(s[0])), 32'd1);
      checkOutput($sformatf("reset busy dut%0d", s + 1), 32'(getBusy(s[0])), 32'd0);
      checkOutput($sformatf("reset done dut%0d", s + 1), 32'(getDone(s[0])), 32'd0);
      checkOutput($sformatf("reset ready dut%0d", s + 1), 32'(getReady(s[0])), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single frames from the table, including the two-stop-bit instance
    for (int i = 0; i < 6; i++) begin
      sendFrame(vecs[i].sel, vecs[i].data, vecs[i].nbits, vecs[i].frame,
                $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Back-to-back words: hold buffer fills and ready drops for 9 cycles
    runStream(1'b0, 8'h3C, 8'hFF, 8'h00, 3, 1'b0, 9, "stream");
    @(posedge clk); #1;

    // Toggling data_in while stalled must not leak into the frames
    runStream(1'b0, 8'h11, 8'h22, 8'hC6, 3, 1'b1, 9, "scramble");
    @(posedge clk); #1;

    // Two stop bits: back-to-back frames every 11 cycles
    runStream(1'b1, 8'h81, 8'h81, 8'h00, 2, 1'b0, 0, "period2");
    @(posedge clk); #1;

    // Reset during data bit 4 of 8'hF0 with 8'h0F waiting in the buffer
    applyStimulus(1'b0, 1'b1, 8'hF0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 8'h0F);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort bit4 line", 32'(getSerial(1'b0)), 32'd0);
    checkOutput("abort bit4 busy", 32'(getBusy(1'b0)), 32'd1);
    checkOutput("abort bit4 ready", 32'(getReady(1'b0)), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort line", 32'(getSerial(1'b0)), 32'd1);
    checkOutput("abort busy", 32'(getBusy(1'b0)), 32'd0);
    checkOutput("abort ready", 32'(getReady(1'b0)), 32'd1);
    checkOutput("abort done", 32'(getDone(1'b0)), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int errs;
      errs = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (getSerial(1'b0) !== 1'b1 || getBusy(1'b0) !== 1'b0) errs++;
      end
      checkOutput("abort stays idle", 32'(errs), 32'd0);
    end
    sendFrame(1'b0, 8'h69, 10, 11'b00011010011, "after abort");
    @(posedge clk); #1;

    // Loopback: 1000 random words streamed, decoded by a bench receiver
    begin
      logic [7:0] sent[$];
      logic [7:0] rx[$];
      int startT;
      int lastT;
      startT = -1;
      lastT  = 0;
      fork
        begin
          for (int i = 0; i < 1000; i++) begin
            logic [7:0] w;
            int guard;
            w = 8'($urandom_range(0, 255));
            sent.push_back(w);
            applyStimulus(1'b0, 1'b1, w);
            for (guard = 0; guard < 40; guard++) begin
              @(negedge clk);
              if (getReady(1'b0)) break;
            end
            if (guard == 40) begin
              checkOutput("loop accept timeout", 32'd0, 32'd1);
              break;
            end
            @(posedge clk); #1;
          end
          applyStimulus(1'b0, 1'b0, 8'h00);
        end
        begin
          int t;
          int cnt;
          bit inFrame;
          logic b;
          logic [7:0] sh;
          t = 0;
          cnt = 0;
          inFrame = 1'b0;
          sh = 8'h00;
          while (rx.size() < 1000 && t < 10100) begin
            @(posedge clk); #1;
            t++;
            b = getSerial(1'b0);
            if (!inFrame) begin
              if (b === 1'b0) begin
                inFrame = 1'b1;
                cnt = 0;
                if (startT < 0) startT = t;
              end
            end else begin
              cnt++;
              if (cnt <= 8) begin
                sh = {sh[6:0], b};
              end else begin
                checkOutput("loop stop bit", 32'(b), 32'd1);
                rx.push_back(sh);
                inFrame = 1'b0;
                lastT = t;
              end
            end
          end
        end
      join
      checkOutput("loop frame count", 32'(rx.size()), 32'd1000);
      for (int i = 0; i < rx.size() && i < sent.size(); i++) begin
        checkOutput($sformatf("loop word%0d", i), 32'(rx[i]), 32'(sent[i]));
      end
      checkOutput("loop span", 32'(lastT - startT), 32'd9999);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
